// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PCs to a synchronous RAM, buffers returned
// words in a small FIFO and hands {instruction, pc} to decode.
//
// Parameters:
//   START_ADDRESS  PC loaded at reset
//   FIFO_DEPTH     buffer entries (power of two, >= 2)
// Ports:
//   clock          system clock, rising edge
//   rst            asynchronous active-low reset
//   i_address      fetch address to RAM (fetch_pc)
//   instruction    RAM word for the address sampled at the previous edge
//   jump           redirect request, flushes in-flight and buffered words
//   jump_target    redirect PC, low two bits forced to zero
//   instr_out      instruction presented to decode
//   pc_out         address of instr_out
//   instr_valid    instr_out/pc_out valid
//   instr_ready    decode accepts (transfer on instr_valid && instr_ready)
// Optional macro FETCH_BYPASS_EN: a word returning into an empty FIFO is
// presented in the same cycle and skips the FIFO if decode takes it.

module fetch_unit #(
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
    parameter int          FIFO_DEPTH    = 2
) (
    input  logic        clock,
    input  logic        rst,
    output logic [31:0] i_address,
    input  logic [31:0] instruction,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;

    logic [31:0]   mem_instr [FIFO_DEPTH];
    logic [31:0]   mem_pc    [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          issue;
    logic [CW:0]   occupancy;

    assign i_address  = fetch_pc;
    assign fifo_empty = (count == '0);

    // A returning word is only kept if no redirect squashes it this cycle.
    assign push = inflight && !jump;

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && push;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        if (bypass) begin
            instr_valid = 1'b1;
            instr_out   = instruction;
            pc_out      = inflight_pc;
        end else begin
            instr_valid = !fifo_empty;
            instr_out   = mem_instr[rd_ptr];
            pc_out      = mem_pc[rd_ptr];
        end
    end

    assign pop     = instr_valid && instr_ready;
    assign fifo_rd = pop && !fifo_empty;
    // A bypassed word that decode takes never lands in the buffer.
    assign fifo_wr = push && !(bypass && instr_ready);

    // Slots committed after this edge: stored + returning - leaving.
    // Issuing only when this is below depth prevents overflow.
    assign occupancy = {1'b0, count}
                     + (CW+1)'(inflight)
                     - (CW+1)'(pop);
    assign issue = !jump && (occupancy < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= START_ADDRESS;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_instr[i] <= 32'h0;
                mem_pc[i]    <= 32'h0;
            end
        end else if (jump) begin
            fetch_pc <= jump_target & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end else begin
                inflight <= 1'b0;
            end
            if (fifo_wr) begin
                mem_instr[wr_ptr] <= instruction;
                mem_pc[wr_ptr]    <= inflight_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(fifo_wr) - CW'(fifo_rd);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.

module tb_fetch_unit;

    localparam logic [31:0] START = 32'h0000_0000;
    localparam int          DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        rst;
    logic [31:0] i_address;
    logic [31:0] ram_data;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .START_ADDRESS(START),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .rst(rst),
        .i_address(i_address),
        .instruction(ram_data),
        .jump(jump),
        .jump_target(jump_target),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    // Synchronous RAM: word for the address sampled at this edge.
    always @(posedge clock) ram_data <= ram_word(i_address);

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    bit          m_infl;
    logic [31:0] m_ipc;
    logic [31:0] m_fpc;
    bit          exp_v;

    logic        obs_valid;
    logic [31:0] obs_addr;
    logic [31:0] obs_pc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_infl = 1'b0;
        m_ipc  = 32'h0;
        m_fpc  = START;
    endtask

    task automatic compare();
        ent_t h;
        bit   byp;
        byp   = BYP && (q.size() == 0) && m_infl && !jump;
        exp_v = (q.size() != 0) || byp;
        if (q.size() != 0) begin
            h = q[0];
        end else begin
            h.ins = ram_word(m_ipc);
            h.pc  = m_ipc;
        end
        chk("i_address", i_address, m_fpc);
        chk("instr_valid", instr_valid, exp_v);
        if (exp_v) begin
            chk("instr_out", instr_out, h.ins);
            chk("pc_out", pc_out, h.pc);
        end
        obs_valid = instr_valid;
        obs_addr  = i_address;
        obs_pc    = pc_out;
    endtask

    task automatic model_step();
        bit pop;
        pop = exp_v && instr_ready;
        if (jump) begin
            q.delete();
            m_infl = 1'b0;
            m_fpc  = jump_target & 32'hFFFF_FFFC;
        end else begin
            if (m_infl) q.push_back({ram_word(m_ipc), m_ipc});
            if (pop) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                m_infl = 1'b1;
                m_ipc  = m_fpc;
                m_fpc  = m_fpc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic step(input bit j, input logic [31:0] t, input bit r);
        @(negedge clock);
        jump        = j;
        jump_target = t;
        instr_ready = r;
        #1;
        compare();
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clock);
        jump = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", i_address, START);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_pc_out", pc_out, 0);
        model_reset();
        @(posedge clock);
        #2 rst = 1'b1;
    endtask

    task automatic after_jump(input logic [31:0] tgt);
        int first;
        int nv;
        first = -1;
        nv    = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (i == 0) chk("jump_addr", obs_addr, tgt);
            if (i == 1) chk("jump_next_addr", obs_addr, tgt + 32'd4);
            if (obs_valid) begin
                if (first < 0) first = i;
                chk("jump_pc_seq", obs_pc, tgt + 32'(4 * nv));
                nv++;
            end
        end
        chk("jump_first_valid", 32'(first), BYP ? 32'd1 : 32'd2);
    endtask

    logic [31:0] a_addr [6];
    logic        a_v    [6];
    logic [31:0] a_pc   [6];
    int          lat;

    initial begin
        rst         = 1'b0;
        jump        = 1'b0;
        jump_target = 32'h0;
        instr_ready = 1'b0;
        model_reset();
        lat = BYP ? 1 : 2;

        // Streaming from reset with decode always ready.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b1);
            a_addr[i] = obs_addr;
            a_v[i]    = obs_valid;
            a_pc[i]   = obs_pc;
        end
        chk("stream_addr0", a_addr[0], 32'h0);
        chk("stream_addr1", a_addr[1], 32'h4);
        chk("stream_addr2", a_addr[2], 32'h8);
        chk("stream_pre_valid", a_v[lat-1], 0);
        chk("stream_valid", a_v[lat], 1);
        chk("stream_pc0", a_pc[lat], 32'h0);
        chk("stream_pc1", a_pc[lat+1], 32'h4);
        chk("stream_pc2", a_pc[lat+2], 32'h8);

        // Decode stall fills the buffer, then drains without gaps.
        do_reset();
        for (int i = 0; i < lat + 5; i++) step(1'b0, 32'h0, 1'b0);
        chk("stall_addr", obs_addr, 32'h8);
        chk("stall_valid", obs_valid, 1);
        chk("stall_pc", obs_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk("drain_valid", obs_valid, 1);
            chk("drain_pc", obs_pc, 32'(4 * i));
        end

        // Jump while the buffer is full.
        do_reset();
        for (int i = 0; i < lat + 5; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b0);
        after_jump(32'h0000_0100);

        // Jump while the word for 0x8 is returning.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0103, 1'b1);
        after_jump(32'h0000_0100);

        // Fetch address wraps past the top of memory.
        do_reset();
        step(1'b1, 32'hFFFF_FFFE, 1'b1);
        after_jump(32'hFFFF_FFFC);

        // Randomized traffic with occasional mid-stream resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0)
                ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                : $urandom;
            step($urandom_range(0, 11) == 0, t,
                 $urandom_range(0, 3) != 0);
            if (n % 700 == 699) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
